hpi_access_controller: RTL

- Sequences all accesses on the EZ-OTG host-port interface (usb_DATA/usb_ADDR/usb_RD_N/usb_WR_N/usb_CS_N/usb_RST_N/usb_INT).
- Arbitrates the bus between two requesters, e.g. the CPU bridge and a hardware keycode poller, using round-robin.
- Generates programmable setup/strobe/hold/recovery timing and performs the chip reset pulse after system reset.
- Synchronizes usb_INT for the fabric.

---
 rtl/hpi_access_controller.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/hpi_access_controller.sv
`timescale 1ns/1ps
// hpi_access_controller: sequences EZ-OTG HPI bus cycles for two
// round-robin requesters, with chip reset pulse and INT synchronizer.
module hpi_access_controller #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 2,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 2,
  parameter int RESET_CYC   = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic        usb_irq,
  inout  wire  [15:0] usb_DATA,
  output logic [1:0]  usb_ADDR,
  output logic        usb_RD_N,
  output logic        usb_WR_N,
  output logic        usb_CS_N,
  output logic        usb_RST_N,
  input  logic        usb_INT
);

  localparam logic [2:0] S_CHIPRST = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_L = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] SET_L = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STB_L = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HLD_L = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REC_L = CNT_W'(RECOVER_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [1:0]       adr_q, adr_d;
  logic [15:0]      wdat_q, wdat_d;

  logic             act_d;
  logic             cap_rd;
  logic             ack_go;

  logic             cs_n_q, rd_n_q, wr_n_q, rst_n_q;
  logic             drv_q;
  logic [1:0]       addr_o_q;
  logic [15:0]      dout_q;
  logic             ack0_q, ack1_q;
  logic [15:0]      rdata0_q, rdata1_q;
  logic             irq_m_q, irq_q;

  // Phase sequencing and round-robin grant taken only in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    unique case (state_q)
      S_CHIPRST: begin
        if (cnt_q == RST_L) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = (req0 && req1) ? ~ptr_q : req1;
          ptr_d   = gnt_d;
          we_d    = gnt_d ? we1 : we0;
          adr_d   = gnt_d ? addr1 : addr0;
          wdat_d  = gnt_d ? wdata1 : wdata0;
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SET_L) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_STROBE: begin
        if (cnt_q == STB_L) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == HLD_L) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_RECOVER: begin
        if (cnt_q == REC_L) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = S_CHIPRST;
        cnt_d   = '0;
      end
    endcase
  end

  assign act_d  = (state_d == S_SETUP) ||
                  (state_d == S_STROBE) ||
                  (state_d == S_HOLD);
  assign cap_rd = (state_q == S_STROBE) &&
                  (state_d == S_HOLD) && !we_q;
  assign ack_go = (state_q == S_HOLD) &&
                  (state_d == S_RECOVER);

  // Controller state, phase counter and latched winner request
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_CHIPRST;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
    end
  end

  // HPI pins registered from next state so strobes never glitch
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rst_n_q  <= 1'b0;
      addr_o_q <= '0;
      dout_q   <= '0;
      drv_q    <= 1'b0;
    end else begin
      cs_n_q   <= !act_d;
      rd_n_q   <= !((state_d == S_STROBE) && !we_d);
      wr_n_q   <= !((state_d == S_STROBE) && we_d);
      rst_n_q  <= (state_d != S_CHIPRST);
      addr_o_q <= act_d ? adr_d : 2'b00;
      dout_q   <= wdat_d;
      drv_q    <= act_d && we_d;
    end
  end

  // Completion pulse and per-requester read data capture
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= ack_go && !gnt_q;
      ack1_q <= ack_go && gnt_q;
      if (cap_rd && !gnt_q) begin
        rdata0_q <= usb_DATA;
      end
      if (cap_rd && gnt_q) begin
        rdata1_q <= usb_DATA;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous chip interrupt
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irq_m_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_m_q <= usb_INT;
      irq_q   <= irq_m_q;
    end
  end

  assign usb_DATA  = drv_q ? dout_q : 16'hzzzz;
  assign usb_ADDR  = addr_o_q;
  assign usb_RD_N  = rd_n_q;
  assign usb_WR_N  = wr_n_q;
  assign usb_CS_N  = cs_n_q;
  assign usb_RST_N = rst_n_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != S_IDLE);
  assign usb_irq   = irq_q;

endmodule
